// File: rtl/led_sel_ctrl.sv
// Credit / vend / refund controller for the seller LED stage.
// Drives seven active-low pattern selects, exactly one of which is low at any time.
module led_sel_ctrl #(
    parameter int unsigned PRICE       = 2,
    parameter int unsigned MAX_CREDIT  = 4,
    parameter int unsigned FLASH_CYC   = 50_000_000,
    parameter int unsigned PULSE_CYC   = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_in,
    input  logic       vend_req,
    input  logic       cancel,
    output logic       led_idle_rst_n,
    output logic       led1_rst_n,
    output logic       led2_rst_n,
    output logic       led3_rst_n,
    output logic       led4_rst_n,
    output logic       led_flash_rst_n,
    output logic       led_pulse_rst_n,
    output logic [2:0] credit,
    output logic       busy
);

    localparam int unsigned MAX_FP  = (FLASH_CYC > PULSE_CYC) ? FLASH_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC = (MAX_FP > TIMEOUT_CYC) ? MAX_FP : TIMEOUT_CYC;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] FLASH_END   = TW'(FLASH_CYC - 1);
    localparam logic [TW-1:0] PULSE_END   = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    PRICE_C     = 3'(PRICE);
    localparam logic [2:0]    MAX_C       = 3'(MAX_CREDIT);

    // Select vector bit order: {pulse, flash, led4, led3, led2, led1, idle}
    localparam logic [6:0] SEL_IDLE  = 7'b111_1110;
    localparam logic [6:0] SEL_FLASH = 7'b101_1111;
    localparam logic [6:0] SEL_PULSE = 7'b011_1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_FLASH  = 2'd2,
        S_PULSE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    credit_q, credit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    sel_q;
    logic          busy_q;

    function automatic logic [6:0] sel_decode(input state_t s, input logic [2:0] c);
        logic [6:0] sel;
        case (s)
            S_IDLE:  sel = SEL_IDLE;
            S_CREDIT: begin
                case (c)
                    3'd1:    sel = 7'b111_1101;
                    3'd2:    sel = 7'b111_1011;
                    3'd3:    sel = 7'b111_0111;
                    3'd4:    sel = 7'b110_1111;
                    default: sel = SEL_IDLE;
                endcase
            end
            S_FLASH: sel = SEL_FLASH;
            S_PULSE: sel = SEL_PULSE;
            default: sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

    // Next-state logic; cancel outranks vend_req, which outranks coin_in.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: begin
                if (coin_in) begin
                    state_d  = S_CREDIT;
                    credit_d = 3'd1;
                    timer_d  = '0;
                end else begin
                    timer_d  = '0;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    state_d  = S_PULSE;
                    credit_d = 3'd0;
                    timer_d  = '0;
                end else if (vend_req) begin
                    timer_d = '0;
                    if (credit_q >= PRICE_C) begin
                        credit_d = credit_q - PRICE_C;
                        state_d  = S_FLASH;
                    end else begin
                        credit_d = credit_q;
                    end
                end else if (coin_in) begin
                    timer_d = '0;
                    if (credit_q < MAX_C) begin
                        credit_d = credit_q + 3'd1;
                    end else begin
                        credit_d = credit_q;
                    end
                end else if (timer_q == TIMEOUT_END) begin
                    state_d  = S_PULSE;
                    credit_d = 3'd0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FLASH: begin
                if (timer_q == FLASH_END) begin
                    timer_d = '0;
                    state_d = (credit_q != 3'd0) ? S_CREDIT : S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_PULSE: begin
                if (timer_q == PULSE_END) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = 3'd0;
                timer_d  = '0;
            end
        endcase
    end

    // State, credit, timer and registered select/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            credit_q <= 3'd0;
            timer_q  <= '0;
            sel_q    <= SEL_IDLE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            sel_q    <= sel_decode(state_d, credit_d);
            busy_q   <= (state_d == S_FLASH) || (state_d == S_PULSE);
        end
    end

    assign led_idle_rst_n  = sel_q[0];
    assign led1_rst_n      = sel_q[1];
    assign led2_rst_n      = sel_q[2];
    assign led3_rst_n      = sel_q[3];
    assign led4_rst_n      = sel_q[4];
    assign led_flash_rst_n = sel_q[5];
    assign led_pulse_rst_n = sel_q[6];
    assign credit          = credit_q;
    assign busy            = busy_q;

endmodule
